// File: rtl/qbus_pkg.sv
// Shared definitions for the QBUS slave: FSM states, I/O register addresses
// and the byte-lane merge helper.
package qbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_RAM,
    S_RD_DATA,
    S_WR,
    S_IACK,
    S_REPLY,
    S_HOLD
  } state_t;

  localparam logic [15:0] RAM_LIMIT = 16'o100000;
  localparam logic [12:0] TTY_RCSR  = 13'o17560;
  localparam logic [12:0] TTY_RBUF  = 13'o17562;
  localparam logic [12:0] TTY_XCSR  = 13'o17564;
  localparam logic [12:0] TTY_XBUF  = 13'o17566;
  localparam logic [12:0] DISP_ADDR = 13'o17714;

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_v,
                                              input logic [15:0] wd,
                                              input logic [1:0]  we);
    return {we[1] ? wd[15:8] : old_v[15:8], we[0] ? wd[7:0] : old_v[7:0]};
  endfunction

endpackage

// File: rtl/qbus_tty_tmr.sv
// Terminal transmitter busy timer and vectored-interrupt pending logic.
module qbus_tty_tmr #(
  parameter int TX_DLY = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic csr_we,
  input  logic csr_ie,
  input  logic xbuf_we,
  input  logic iack,
  output logic tx_rdy,
  output logic tx_ie,
  output logic virq_n
);

  localparam int CW = $clog2(TX_DLY + 1);

  logic [CW-1:0] cnt;
  logic          pend;
  logic          done;

  assign done   = !tx_rdy && (cnt == '0);
  assign virq_n = ~(tx_rdy & tx_ie & pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_rdy <= 1'b1;
      tx_ie  <= 1'b0;
      pend   <= 1'b0;
      cnt    <= '0;
    end else begin
      if (csr_we)
        tx_ie <= csr_ie;
      // A character write reloads the count even while a previous one is running.
      if (xbuf_we) begin
        tx_rdy <= 1'b0;
        cnt    <= CW'(TX_DLY - 1);
      end else if (done) begin
        tx_rdy <= 1'b1;
      end else if (!tx_rdy) begin
        cnt <= cnt - CW'(1);
      end
      if (iack || xbuf_we)
        pend <= 1'b0;
      else if ((csr_we && csr_ie && tx_rdy) || (done && tx_ie))
        pend <= 1'b1;
    end
  end

endmodule

// File: rtl/qbus_slv.sv
// QBUS slave: RAM window, console transmitter registers, display register
// and vectored interrupt for the transmitter.
module qbus_slv
  import qbus_pkg::*;
#(
  parameter int          RPLY_DLY = 1,
  parameter int          TX_DLY   = 500,
  parameter logic [15:0] VECTOR   = 16'o000064
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  input  logic        sync_n,
  input  logic        din_n,
  input  logic        dout_n,
  input  logic        wtbt_n,
  input  logic        bs_n,
  input  logic        iako_n,
  output logic        rply_n,
  output logic        virq_n,
  output logic [13:0] ram_a,
  output logic [15:0] ram_wd,
  input  logic [15:0] ram_rd,
  output logic        ram_re,
  output logic [1:0]  ram_we,
  output logic [7:0]  tty_data,
  output logic        tty_stb,
  output logic [15:0] disp
);

  localparam int DW = $clog2(RPLY_DLY + 1) + 1;

  state_t        state;
  logic [15:0]   ad_r, addr, io_rdata;
  logic          sync_r, sync_q, din_r, dout_r, wtbt_r, bs_r, iako_r;
  logic          io, rd_wait, rx_ie, csr_we, csr_ie, iack;
  logic          tx_rdy, tx_ie;
  logic          ram_sel, tty_sel, disp_sel, sel, sync_fall, sync_rise;
  logic [1:0]    we_lanes;
  logic [DW-1:0] dly;

  always_ff @(posedge clk) begin
    if (rst) begin
      ad_r   <= '0;
      sync_r <= 1'b1;
      sync_q <= 1'b1;
      din_r  <= 1'b1;
      dout_r <= 1'b1;
      wtbt_r <= 1'b1;
      bs_r   <= 1'b1;
      iako_r <= 1'b1;
    end else begin
      ad_r   <= ad_in;
      sync_r <= sync_n;
      sync_q <= sync_r;
      din_r  <= din_n;
      dout_r <= dout_n;
      wtbt_r <= wtbt_n;
      bs_r   <= bs_n;
      iako_r <= iako_n;
    end
  end

  assign sync_fall = sync_q & ~sync_r;
  assign sync_rise = ~sync_q & sync_r;
  assign ram_a     = addr[14:1];
  assign ram_sel   = !io && (addr < RAM_LIMIT);
  assign tty_sel   = io && (addr[12:3] == TTY_RCSR[12:3]);
  assign disp_sel  = io && (addr[12:1] == DISP_ADDR[12:1]);
  assign sel       = ram_sel | tty_sel | disp_sel;
  assign we_lanes  = wtbt_r ? 2'b11 : {addr[0], ~addr[0]};

  always_comb begin
    io_rdata = '0;
    if (disp_sel)
      io_rdata = disp;
    else
      case ({addr[12:1], 1'b0})
        TTY_RCSR: io_rdata = {9'b0, rx_ie, 6'b0};
        TTY_XCSR: io_rdata = {8'b0, tx_rdy, tx_ie, 6'b0};
        TTY_RBUF: io_rdata = '0;
        default:  io_rdata = '0;
      endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rply_n   <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
      ram_re   <= 1'b0;
      ram_we   <= '0;
      ram_wd   <= '0;
      tty_stb  <= 1'b0;
      tty_data <= '0;
      csr_we   <= 1'b0;
      csr_ie   <= 1'b0;
      iack     <= 1'b0;
      rx_ie    <= 1'b0;
      disp     <= '0;
      addr     <= '0;
      io       <= 1'b0;
      dly      <= '0;
      rd_wait  <= 1'b0;
    end else begin
      ram_re  <= 1'b0;
      ram_we  <= '0;
      tty_stb <= 1'b0;
      csr_we  <= 1'b0;
      iack    <= 1'b0;
      if (state != S_IDLE && sync_rise) begin
        state  <= S_IDLE;
        rply_n <= 1'b1;
        ad_oe  <= 1'b0;
      end else begin
        case (state)
          S_IDLE:
            if (sync_fall) begin
              addr  <= ad_r;
              io    <= ~bs_r;
              state <= S_ADDR;
            end else if (sync_r && !din_r && !iako_r) begin
              // Only a pending request answers; otherwise park until DIN clears.
              if (!virq_n) begin
                ad_out <= VECTOR;
                ad_oe  <= 1'b1;
                iack   <= 1'b1;
                dly    <= '0;
                state  <= S_RD_DATA;
              end else begin
                state <= S_IACK;
              end
            end
          S_ADDR:
            if (!din_r && sel) begin
              if (ram_sel) begin
                ram_re  <= 1'b1;
                rd_wait <= 1'b1;
                state   <= S_RD_RAM;
              end else begin
                ad_out <= io_rdata;
                ad_oe  <= 1'b1;
                dly    <= '0;
                state  <= S_RD_DATA;
              end
            end else if (!dout_r && sel) begin
              state <= S_WR;
              if (ram_sel) begin
                ram_we <= we_lanes;
                ram_wd <= ad_r;
              end else if (disp_sel) begin
                disp <= merge_bytes(disp, ad_r, we_lanes);
              end else begin
                case ({addr[12:1], 1'b0})
                  TTY_RCSR: rx_ie <= ad_r[6];
                  TTY_XCSR: begin
                    csr_we <= 1'b1;
                    csr_ie <= ad_r[6];
                  end
                  TTY_XBUF: begin
                    tty_stb  <= 1'b1;
                    tty_data <= ad_r[7:0];
                  end
                  default: ;
                endcase
              end
            end
          S_RD_RAM:
            // First cycle lets the RAM sample ram_re; data is valid in the second.
            if (rd_wait) begin
              rd_wait <= 1'b0;
            end else begin
              ad_out <= ram_rd;
              ad_oe  <= 1'b1;
              dly    <= '0;
              state  <= S_RD_DATA;
            end
          S_RD_DATA:
            if (dly == DW'(RPLY_DLY - 1)) begin
              rply_n <= 1'b0;
              state  <= S_REPLY;
            end else begin
              dly <= dly + DW'(1);
            end
          S_WR: begin
            rply_n <= 1'b0;
            state  <= S_REPLY;
          end
          S_IACK:
            if (din_r) state <= S_IDLE;
          S_REPLY:
            if (din_r && dout_r) begin
              rply_n <= 1'b1;
              ad_oe  <= 1'b0;
              state  <= S_HOLD;
            end
          S_HOLD:
            if (sync_r) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  qbus_tty_tmr #(.TX_DLY(TX_DLY)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .csr_we  (csr_we),
    .csr_ie  (csr_ie),
    .xbuf_we (tty_stb),
    .iack    (iack),
    .tx_rdy  (tx_rdy),
    .tx_ie   (tx_ie),
    .virq_n  (virq_n)
  );

endmodule

// File: doc/qbus_slv.md
QBUS_SLV -- requirements
Module: qbus_slv

Interface
REQ-001 The block SHALL have parameter RPLY_DLY, default 1, meaning the number of cycles from data valid on ad_out to rply_n assertion.
REQ-002 The block SHALL have parameter TX_DLY, default 500, meaning the number of cycles for which the terminal transmitter is busy after a data write.
REQ-003 The block SHALL have parameter VECTOR, default 16'o000064, meaning the vector value returned during an interrupt acknowledge.
REQ-004 The block SHALL run on one clock and use a synchronous, active-high reset, with ports named clk and rst.
REQ-005 Port list, in order (name  direction  width  meaning):
 clk  in  1  clock;
 rst  in  1  synchronous active-high reset;
 ad_in  in  16  bus address/data, true polarity;
 ad_out  out  16  read data/vector, true polarity;
 ad_oe  out  1  ad_out drive enable;
 sync_n, din_n, dout_n, wtbt_n, bs_n, iako_n  in  1 each  QBUS strobes, active low;
 rply_n  out  1  reply, active low;
 virq_n  out  1  vectored interrupt request, active low;
 ram_a  out  14  RAM word address (bus address bits [14:1]);
 ram_wd  out  16  RAM write data;
 ram_rd  in  16  RAM read data, valid 1 cycle after ram_re;
 ram_re  out  1  one-cycle RAM read strobe;
 ram_we  out  2  byte write enables, bit 1 = high byte;
 tty_data  out  8  transmitted character;
 tty_stb  out  1  one-cycle transmit strobe;
 disp  out  16  display register.

Function
REQ-006 All bus inputs SHALL be registered once before use, and every latency below SHALL be counted from that registered sample.
REQ-007 The block SHALL implement a state machine with states IDLE, ADDR, RD_RAM, RD_DATA, WR, IACK, REPLY and HOLD.
REQ-008 On a sync_n high-to-low transition in IDLE, the block SHALL latch addr = ad_in and io = ~bs_n, then enter ADDR.
REQ-009 The block SHALL decode the latched address as follows:
 - RAM selected when io = 0 and addr < 16'o100000;
 - TTY selected when io = 1 and addr[12:0] is in 17560..17567;
 - DISP selected when io = 1 and addr[12:0] is 17714 or 17715;
 - no other address is selected.
REQ-010 In ADDR, when din_n is low and the address is RAM-selected, the block SHALL pulse ram_re and enter RD_RAM, then capture ram_rd into ad_out on the next cycle and enter RD_DATA.
REQ-011 In ADDR, when din_n is low and the address is TTY- or DISP-selected, the block SHALL load ad_out directly and enter RD_DATA with the following values:
 - 17560 reads rx_ie<<6;
 - 17564 reads (tx_rdy<<7)|(tx_ie<<6);
 - 17562 and 17566 read 0;
 - DISP reads disp.
REQ-012 In RD_DATA, the block SHALL hold ad_oe = 1 and, after RPLY_DLY cycles, assert rply_n = 0 and enter REPLY.
REQ-013 In ADDR, when dout_n is low and the address is selected, the block SHALL perform the write for exactly one cycle, assert rply_n = 0 on the next cycle, and enter REPLY.
REQ-014 Write byte enables SHALL be ram_we = 2'b11 when wtbt_n = 1, and {addr[0], ~addr[0]} when wtbt_n = 0.
REQ-015 Writes to I/O registers SHALL have the following effects:
 - 17560 sets rx_ie = ad_in[6];
 - 17564 sets tx_ie = ad_in[6];
 - 17566 pulses tty_stb with tty_data = ad_in[7:0] and clears tx_rdy;
 - DISP is written with byte-lane rules identical to RAM.
REQ-016 In REPLY, the block SHALL hold rply_n low and ad_oe as set until the active strobe (din_n or dout_n) returns high, then release rply_n and ad_oe on the same edge and enter HOLD.
REQ-017 In HOLD, the block SHALL return to IDLE when sync_n is high.
REQ-018 An unselected address SHALL never assert rply_n, leaving the bus to time out, and SHALL wait in ADDR until sync_n is high.
REQ-019 In IDLE, with sync_n high, din_n low, iako_n low and virq_n low, the block SHALL drive ad_out = VECTOR with ad_oe = 1, assert rply_n after RPLY_DLY cycles, and clear the pending request.
REQ-020 The block SHALL handle a vector acknowledge with no pending request as follows:
 - it SHALL never assert rply_n;
 - it SHALL remain in IACK until din_n is high.
REQ-021 The transmitter busy timing SHALL work as follows:
 - clearing tx_rdy loads a counter with TX_DLY-1;
 - tx_rdy sets when the counter reaches 0.
REQ-022 The interrupt output SHALL be virq_n = ~(tx_rdy & tx_ie & pend).
 - pend sets when tx_rdy rises with tx_ie = 1, or when 17564 is written with tx_ie = 1 while tx_rdy = 1.
 - pend clears on acknowledge or on a write to 17566.
REQ-023 In every state other than IDLE, a sync_n rising edge SHALL force the next state to IDLE with rply_n = 1 and ad_oe = 0.
REQ-024 A write to 17566 while the counter is running SHALL restart the count.

Reset
REQ-025 While rst = 1, the block SHALL set the following values at the next edge, regardless of the current state:
 - state = IDLE;
 - rply_n = 1, virq_n = 1;
 - ad_oe = 0, ad_out = 0;
 - ram_re = 0, ram_we = 0, tty_stb = 0;
 - tx_rdy = 1, tx_ie = 0, rx_ie = 0, pend = 0;
 - disp = 0, counter = 0.

Structure
REQ-026 The state encoding, the octal register-address constants and the RAM limit 16'o100000 SHALL be placed in the shared package qbus_pkg.
REQ-027 The transmitter timer and interrupt logic SHALL be implemented as the sub-module qbus_tty_tmr.

Verification
REQ-028 RAM read: ram_rd = 16'o123456 at 16'o001000 -> ram_re pulse, ad_out = 16'o123456 with ad_oe = 1, rply_n low 1 cycle later, released when din_n rises.
REQ-029 Byte write: 16'o000777 with wtbt_n = 0 at odd address 16'o001001 -> ram_we = 2'b10, then rply_n low.
REQ-030 TTY: write 0x41 to 17566 -> tty_stb pulse with tty_data = 8'h41; 17564 then reads 0 in bit 7, and reads 16'o000200 after 500 cycles.
REQ-031 Interrupt: write 16'o000100 to 17564 while tx_rdy = 1 -> virq_n = 0; an IAKO cycle returns 16'o000064 and virq_n returns to 1.
REQ-032 Unselected address 16'o017700 with bs_n = 0 -> rply_n never asserted, and the block is in IDLE after sync_n rises.
REQ-033 rst = 1 asserted during REPLY -> rply_n = 1 and ad_oe = 0 at the next edge.
